// File: rtl/dft_force_pkg.sv
// Shared types and constants for the XSTEPDOWN/XFAULT serial force controller.
// Holds the FSM state encoding, default sizing and the settle-counter width helper.
package dft_force_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FORCE = 2'd2
  } force_state_e;

  localparam int NBITS_DEF    = 8;
  localparam int HOLD_CYC_DEF = 4;

  // Counter only ever holds HOLD_CYC-1 down to 0; floor of 1 bit keeps a bad HOLD_CYC from
  // producing a zero-width vector before the elaboration check reports it.
  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/dft_force_chain.sv
// NBITS shift/capture register for the fault-force test chain.
// Shifts toward bit 0 with tdi entering at the MSB; bit 0 is the serial tap.
module dft_force_chain
  import dft_force_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             capture_en,
  input  logic             tdi,
  input  logic [NBITS-1:0] cap_i,
  output logic [NBITS-1:0] chain,
  output logic             tdo
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (shift_en) begin
      chain <= {tdi, chain[NBITS-1:1]};
    end else if (capture_en) begin
      chain <= cap_i;
    end
  end

  // Combinational tap: the next bit to leave is visible before the shift edge.
  assign tdo = chain[0];

endmodule

// File: rtl/dft_fault_force.sv
// Serial-in / parallel force controller: loads force_val from the test chain and
// asserts force_en onto the fault nodes after a HOLD_CYC settle window.
module dft_fault_force
  import dft_force_pkg::*;
#(
  parameter int NBITS    = NBITS_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic             tck,
  input  logic             trstn,
  input  logic             CELG,
  input  logic             CELSUB,
  input  logic             CELV,
  input  logic             tdi_FAULTforce,
  input  logic             ten_FAULTforce,
  input  logic             shift,
  input  logic             capture,
  input  logic             update,
  input  logic [NBITS-1:0] cap_i,
  output logic             tdo_FAULTforce,
  output logic [NBITS-1:0] force_val,
  output logic             force_en,
  output logic             busy
);

  localparam int CNT_W = cnt_width(HOLD_CYC);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("dft_fault_force: HOLD_CYC must be >= 1");
  end

  // Supply pins are physical connections only.
  logic unused_supplies;
  assign unused_supplies = CELG ^ CELSUB ^ CELV;

  force_state_e     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [NBITS-1:0] chain;
  logic             shift_cmd, capture_cmd, update_cmd;
  logic             load_force;

  // Fixed priority shift > capture > update, all gated by the test enable.
  assign shift_cmd   = ten_FAULTforce & shift;
  assign capture_cmd = ten_FAULTforce & capture & ~shift;
  assign update_cmd  = ten_FAULTforce & update & ~shift & ~capture;

  dft_force_chain #(
    .NBITS(NBITS)
  ) u_chain (
    .clk       (tck),
    .rst_n     (trstn),
    .shift_en  (shift_cmd),
    .capture_en(capture_cmd),
    .tdi       (tdi_FAULTforce),
    .cap_i     (cap_i),
    .chain     (chain),
    .tdo       (tdo_FAULTforce)
  );

  // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_force = 1'b0;
    if (!ten_FAULTforce) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (update_cmd) begin
      state_next = ARM;
      cnt_next   = HOLD_LOAD;
      load_force = 1'b1;
    end else begin
      case (state)
        ARM: begin
          if (cnt == '0) begin
            state_next = FORCE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // force_en and busy are registered from the next state so the fault nodes see a
  // clean flop output rather than a decode of the state bits.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      state     <= IDLE;
      cnt       <= '0;
      force_val <= '0;
      force_en  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      force_en <= (state_next == FORCE);
      busy     <= (state_next == ARM);
      if (load_force) begin
        force_val <= chain;
      end
    end
  end

endmodule

// File: tb/tb_dft_fault_force.sv
// Self-checking bench for dft_fault_force: directed scenarios followed by random
// command traffic, all compared against an edge-level behavioural model.
module tb_dft_fault_force;

  localparam int NB   = 8;
  localparam int HOLD = 4;

  logic          tck = 1'b0;
  logic          trstn;
  logic          CELG = 1'b0, CELSUB = 1'b0, CELV = 1'b1;
  logic          tdi, ten, shift, capture, update;
  logic [NB-1:0] cap_i;
  logic          tdo;
  logic [NB-1:0] force_val;
  logic          force_en, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [NB-1:0] m_chain, m_fv;
  bit            m_en;
  int            m_wait;   // edges remaining until force_en rises; 0 = not settling

  dft_fault_force #(.NBITS(NB), .HOLD_CYC(HOLD)) dut (
    .tck           (tck),
    .trstn         (trstn),
    .CELG          (CELG),
    .CELSUB        (CELSUB),
    .CELV          (CELV),
    .tdi_FAULTforce(tdi),
    .ten_FAULTforce(ten),
    .shift         (shift),
    .capture       (capture),
    .update        (update),
    .cap_i         (cap_i),
    .tdo_FAULTforce(tdo),
    .force_val     (force_val),
    .force_en      (force_en),
    .busy          (busy)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_chain = '0;
    m_fv    = '0;
    m_en    = 1'b0;
    m_wait  = 0;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit c, input bit u,
                            input bit d, input logic [NB-1:0] cv);
    bit took_update = 1'b0;
    if (!t) begin
      m_en   = 1'b0;
      m_wait = 0;
    end else begin
      if (s) m_chain = {d, m_chain[NB-1:1]};
      else if (c) m_chain = cv;
      else if (u) begin
        m_fv        = m_chain;
        m_en        = 1'b0;
        m_wait      = HOLD;
        took_update = 1'b1;
      end
      if (!took_update && m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_en = 1'b1;
      end
    end
  endtask

  // Drives one tck cycle starting at a falling edge and returns at the next falling edge.
  task automatic step(input bit t, input bit s, input bit c, input bit u,
                      input bit d, input logic [NB-1:0] cv);
    ten = t; shift = s; capture = c; update = u; tdi = d; cap_i = cv;
    #1;
    check("tdo", tdo, m_chain[0]);
    @(posedge tck);
    model_edge(t, s, c, u, d, cv);
    #1;
    check("force_val", force_val, m_fv);
    check("force_en", force_en, m_en);
    check("busy", busy, m_wait > 0);
    @(negedge tck);
  endtask

  task automatic shift_byte(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) step(1, 1, 0, 0, v[i], '0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0);
  endtask

  task automatic async_reset(input string tag);
    #2 trstn = 1'b0;
    #1;
    check({tag, "_force_en"}, force_en, 0);
    check({tag, "_force_val"}, force_val, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tdo"}, tdo, 0);
    model_reset();
    @(negedge tck);
    trstn = 1'b1;
  endtask

  initial begin
    logic [NB-1:0] pat;
    logic [NB-1:0] held;
    trstn = 1'b0;
    ten = 0; shift = 0; capture = 0; update = 0; tdi = 0; cap_i = '0;
    model_reset();
    repeat (2) @(negedge tck);
    check("rst_force_val", force_val, 0);
    check("rst_force_en", force_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tdo", tdo, 0);
    trstn = 1'b1;

    // Serial pattern 1,0,1,1,0,0,1,0, first bit in first.
    pat = 8'b0100_1101;
    shift_byte(pat);
    check("tdo_9th", tdo, 1);

    // Load A5, update, watch the settle window.
    shift_byte(8'hA5);
    step(1, 0, 0, 1, 0, '0);
    check("upd_a5_val", force_val, 8'hA5);
    check("upd_a5_en", force_en, 0);
    idle_cycles(3);
    check("a5_busy_pre", busy, 1);
    check("a5_en_pre", force_en, 0);
    idle_cycles(1);
    check("a5_en_4th", force_en, 1);
    check("a5_busy_done", busy, 0);

    // In FORCE: shift 3C (tdo shows A5 going out) and re-update.
    shift_byte(8'h3C);
    check("force_kept_in_shift", force_en, 1);
    step(1, 0, 0, 1, 0, '0);
    check("upd_3c_en_drop", force_en, 0);
    check("upd_3c_val", force_val, 8'h3C);
    idle_cycles(HOLD);
    check("3c_en_back", force_en, 1);

    // Capture 5A and shift it out; force outputs must not move.
    step(1, 0, 1, 0, 0, 8'h5A);
    for (int i = 0; i < NB; i++) begin
      check("cap_tdo_seq", tdo, (8'h5A >> i) & 1);
      step(1, 1, 0, 0, 0, '0);
    end
    check("cap_force_val_held", force_val, 8'h3C);

    // Shift and update together: shift wins, force state unchanged.
    held = force_val;
    step(1, 1, 0, 1, 1, '0);
    check("shift_upd_val", force_val, held);
    check("shift_upd_en", force_en, 1);

    // Update in ARM restarts the window.
    step(1, 0, 0, 1, 0, '0);
    idle_cycles(2);
    step(1, 0, 0, 1, 0, '0);
    idle_cycles(HOLD - 1);
    check("rearm_en_pre", force_en, 0);
    idle_cycles(1);
    check("rearm_en", force_en, 1);

    // Drop ten in FORCE, then re-enable without update.
    held = force_val;
    step(0, 0, 0, 1, 0, '0);
    check("ten0_en", force_en, 0);
    check("ten0_val", force_val, held);
    idle_cycles(HOLD + 2);
    check("reen_no_force", force_en, 0);

    // Async reset mid-ARM and mid-FORCE.
    shift_byte(8'hC3);
    step(1, 0, 0, 1, 0, '0);
    idle_cycles(1);
    async_reset("rst_arm");
    shift_byte(8'h81);
    step(1, 0, 0, 1, 0, '0);
    idle_cycles(HOLD);
    check("pre_rst_force", force_en, 1);
    async_reset("rst_force");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rst_rand");
      end else begin
        step($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
             1'($urandom_range(0, 1)), 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
